// File: rtl/mean_filter_stream.sv
// mean_filter_stream: 3x3 streaming mean filter (line buffers, window, /9 stage); ports: clk, rst, in_valid/in_sof/in_data/bypass in, out_valid/out_sof/out_eof/out_data out, busy, sticky err
module mean_filter_stream #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CH    = 3,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [CH*CW-1:0] in_data,
  input  logic             bypass,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CH*CW-1:0] out_data,
  output logic             busy,
  output logic             err
);
  localparam int PW = CH * CW;
  localparam int AW = $clog2(IMG_W);
  localparam int XW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = CW + 4;
  localparam int MW = SW + 7;
  localparam logic [XW-1:0] XW1  = XW'(IMG_W - 1);
  localparam logic [XW-1:0] XWN  = XW'(IMG_W);
  localparam logic [AW-1:0] AW1  = AW'(IMG_W - 1);
  localparam logic [RW-1:0] RH1  = RW'(IMG_H - 1);
  localparam logic [MW-1:0] MAXV = MW'((1 << CW) - 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [XW-1:0] col;
  logic [RW-1:0] row, crow;
  logic [AW-1:0] ccol, rd;
  logic byp, start, acc, fill_done, last_in, fl_step, rel, err_set;
  logic [PW-1:0] lb0 [IMG_W];
  logic [PW-1:0] lb1 [IMG_W];
  logic [PW-1:0] win [3][3];
  logic s1_v, s1_sof, s1_eof, s1_pass, s2_v, s2_sof, s2_eof, s2_pass;
  logic [SW-1:0] sum [CH];
  logic [SW-1:0] s2_sum [CH];
  logic [MW-1:0] q [CH];
  logic [PW-1:0] s2_ctr, mean;
  // col doubles as the flush step counter (0..IMG_W) once the last input has wrapped it to 0
  always_comb begin
    start     = in_valid && in_sof && state != FLUSH;
    acc       = in_valid && (state == FILL || state == RUN || start);
    fill_done = acc && !in_sof && state == FILL && row == RW'(1) && col == XW'(1);
    last_in   = acc && !in_sof && state == RUN && row == RH1 && col == XW1;
    fl_step   = state == FLUSH && col <= XWN;
    rel       = (acc && !in_sof && state == RUN) || fill_done || fl_step;
    err_set   = in_valid && (state == FLUSH || (state == IDLE && !in_sof));
    rd        = (start || col >= XWN) ? '0 : col[AW-1:0];
    state_n   = start ? FILL : fill_done ? RUN : last_in ? FLUSH :
                (state == FLUSH && out_eof) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      ccol      <= '0;
      crow      <= '0;
      byp       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      s1_v      <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_pass   <= 1'b0;
      s2_v      <= 1'b0;
      s2_sof    <= 1'b0;
      s2_eof    <= 1'b0;
      s2_pass   <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_n;
      err   <= err | err_set;
      busy  <= start | (busy & ~out_eof);
      if (start) begin
        col <= XW'(1);
        row <= '0;
        byp <= bypass;
      end else if (acc) begin
        col <= col == XW1 ? '0 : col + 1'b1;
        row <= col == XW1 ? row + 1'b1 : row;
      end else if (fl_step)
        col <= col + 1'b1;
      if (start) begin
        ccol <= '0;
        crow <= '0;
      end else if (rel) begin
        ccol <= ccol == AW1 ? '0 : ccol + 1'b1;
        crow <= ccol == AW1 ? crow + 1'b1 : crow;
      end
      s1_v      <= rel;
      s1_sof    <= ccol == '0 && crow == '0;
      s1_eof    <= ccol == AW1 && crow == RH1;
      s1_pass   <= byp || ccol == '0 || ccol == AW1 || crow == '0 || crow == RH1;
      s2_v      <= s1_v;
      s2_sof    <= s1_sof;
      s2_eof    <= s1_eof;
      s2_pass   <= s1_pass;
      out_valid <= s2_v;
      out_sof   <= s2_v && s2_sof;
      out_eof   <= s2_v && s2_eof;
      if (s2_v) out_data <= s2_pass ? s2_ctr : mean;
    end
  // the window centre win[1][1] is always the released centre pixel, even across row wraps
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[rd] <= lb0[rd];
      lb0[rd] <= in_data;
    end
    if (acc || fl_step) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1[rd];
      win[1][2] <= lb0[rd];
      win[2][2] <= in_data;
    end
    s2_ctr <= win[1][1];
    s2_sum <= sum;
  end
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum[c] = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          sum[c] = sum[c] + SW'(win[i][j][c*CW +: CW]);
    end
  end
  // divide by 9 as (S*57 + 256) >> 9
  always_comb begin
    mean = '0;
    for (int c = 0; c < CH; c++) begin
      q[c] = (MW'(s2_sum[c]) * MW'(57) + MW'(256)) >> 9;
      mean[c*CW +: CW] = q[c] > MAXV ? MAXV[CW-1:0] : q[c][CW-1:0];
    end
  end
endmodule

// File: doc/mean_filter_stream.md
# mean_filter_stream

Parametrised 3x3 mean filter for the licence-plate pre-processing chain: it accepts a raster-order pixel stream of `CH` packed channels and emits one same-format, same-order smoothed pixel per input pixel. Two internal line buffers, the 3x3 window and a fixed-point divide-by-9 stage are all inside this block. Frame-start tagging, border pass-through, an end-of-frame flush and a per-frame bypass mode extend the earlier row/window/filter chain. The block sits between the camera capture path and the binarisation stage.

## Interface
- `IMG_W`, 640, pixels per line (>= 4)
- `IMG_H`, 480, lines per frame (>= 3)
- `CH`, 3, channels packed per pixel (RGB444 = 3)
- `CW`, 4, bits per channel (1..8)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input pixel present this cycle; no backpressure
- `in_sof`  in  1  qualifies first pixel (row 0, col 0) of a frame
- `in_data`  in  CH*CW  pixel, channel 0 in LSBs
- `bypass`  in  1  sampled on accepted `in_sof`; 1 = pass centre pixel unfiltered for that frame
- `out_valid`  out  1  output pixel present
- `out_sof`  out  1  with first output pixel of a frame
- `out_eof`  out  1  with last output pixel of a frame
- `out_data`  out  CH*CW  filtered pixel
- `busy`  out  1  high from accepted `in_sof` until `out_eof` cycle inclusive
- `err`  out  1  sticky; set on input during FLUSH or pixel before any `in_sof`; cleared only by `rst`

## Operation
- States: IDLE, FILL, RUN, FLUSH. Reset -> IDLE.
- IDLE: ignore `in_valid` without `in_sof` (set `err`). `in_valid & in_sof` -> FILL, col=row=0 counters start.
- FILL: accept pixels until input index IMG_W+1 (row 1, col 1) is accepted -> RUN. No outputs in FILL.
- RUN: each accepted input k+IMG_W+1 releases centre pixel k into the pipeline. After input IMG_W*IMG_H-1 accepted -> FLUSH.
- FLUSH: internally generate the remaining IMG_W+1 centre pixels, one per cycle, from line buffers; `in_valid` ignored (sets `err`, pixel dropped). After last centre issued -> IDLE.
- `in_sof` with `in_valid` in FILL/RUN: abandon current frame (no `out_eof`), restart FILL with this pixel as (0,0); pipelined outputs already issued still drain. `in_sof` in FLUSH: treated as error input, dropped.
- Border centres (row 0, row IMG_H-1, col 0, col IMG_W-1): output = centre pixel unchanged.
- Interior: per channel, S = sum of 9 window values (CW+4 bits); out = (S*57 + 256) >> 9, clamped to 2^CW-1. Channels independent.
- Bypass frame: every output = centre pixel; ordering and latency identical to filtered mode.
- Line buffers: two IMG_W-deep memories of CH*CW bits, addressed by column counter; column wraps IMG_W-1 -> 0 with row increment.
- `rst` mid-frame: all state, counters, pipeline and `err` cleared immediately; line-buffer contents need not be cleared.

## Timing
- Reset values: `out_valid`=0, `out_sof`=0, `out_eof`=0, `out_data`=0, `busy`=0, `err`=0.
- Pipeline latency 3 cycles: centre released at cycle t (input accept or FLUSH step) -> `out_valid` at t+3.
- Throughput: 1 pixel/cycle; `in_valid` may have arbitrary gaps in FILL/RUN; outputs then have matching gaps.
- FLUSH outputs are back-to-back: IMG_W+1 consecutive `out_valid` cycles.
- `out_sof` asserted with centre 0; `out_eof` with centre IMG_W*IMG_H-1; `busy` falls the cycle after `out_eof`.
- New `in_sof` accepted in IDLE on the cycle `busy` falls or later; earlier is FLUSH error.

## Test plan
- IMG_W=4, IMG_H=4, CH=3, CW=4; constant frame 0x777 -> 16 outputs all 0x777, `out_sof` on first, `out_eof` on 16th, last 5 back-to-back after final input.
- Impulse 0xFFF at (1,1), all else 0 -> (1,1),(1,2),(2,1),(2,2) = 0x222; all border outputs 0x000.
- All-0xFFF frame -> interior S=135, (135*57+256)>>9=15 -> 0xFFF, no overflow; CW=8 all-0xFF -> 0xFF.
- Same impulse frame with `bypass`=1 at sof -> outputs equal inputs exactly, identical cycle positions to filtered run.
- Random `in_valid` gaps, then `in_sof` at input index 7 -> first frame produces no `out_eof`, second frame outputs complete and correct; `in_valid` during FLUSH -> `err`=1, pixel dropped, output count still 16.
- `rst` asserted during RUN -> all outputs 0 next edge-independent; new frame after release filters correctly.
